// File: rtl/io_mem_responder.sv
// IO-space byte memory responder: accepts io_req transactions, answers each with a
// fixed-latency io_data_ack pulse carrying read data or an out-of-window error flag.
module io_mem_responder #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                MEM_BYTES = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'hF000_0000,
    parameter int                RESP_LAT  = 1,
    parameter int                MAX_OUTST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  io_req,
    input  logic                  io_wr,
    input  logic [DATA_W/8-1:0]   io_wen,
    input  logic [ADDR_W-1:0]     io_addr,
    input  logic [DATA_W-1:0]     io_wdata,
    input  logic                  io_stall,
    output logic                  io_req_ack,
    output logic [DATA_W-1:0]     io_rdata,
    output logic                  io_data_ack,
    output logic                  io_err
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(MEM_BYTES);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    logic [7:0]          mem_r [MEM_BYTES];
    logic [CNT_W-1:0]    cnt_r;
    logic [RESP_LAT-1:0] vld_r;
    logic [RESP_LAT-1:0] err_r;
    logic [DATA_W-1:0]   dat_r [RESP_LAT];

    logic                accept_s;
    logic                in_win_s;
    logic [OFF_W-1:0]    off_s;
    logic [DATA_W-1:0]   rd_s;

    assign io_req_ack = io_req & ~rst & ~io_stall & (cnt_r < CNT_W'(MAX_OUTST));
    assign accept_s   = io_req & io_req_ack;
    // Window test looks only at the base address; lanes past the top wrap inside the window.
    assign in_win_s   = ((io_addr & ~ADDR_W'(MEM_BYTES - 1)) == BASE_ADDR);
    assign off_s      = io_addr[OFF_W-1:0];

    // Gather read lanes with modulo wrap of the byte offset.
    always_comb begin
        rd_s = '0;
        for (int i = 0; i < LANES; i++) begin
            rd_s[8*i +: 8] = mem_r[off_s + OFF_W'(i)];
        end
    end

    // Commit byte-enabled writes at their accept edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept_s && io_wr && in_win_s) begin
            for (int i = 0; i < LANES; i++) begin
                if (io_wen[i]) begin
                    mem_r[off_s + OFF_W'(i)] <= io_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response shift pipeline and outstanding-request counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r <= '0;
            err_r <= '0;
            cnt_r <= '0;
            for (int i = 0; i < RESP_LAT; i++) begin
                dat_r[i] <= '0;
            end
        end else begin
            vld_r[0] <= accept_s;
            err_r[0] <= accept_s & ~in_win_s;
            dat_r[0] <= (accept_s && !io_wr && in_win_s) ? rd_s : '0;
            for (int i = 1; i < RESP_LAT; i++) begin
                vld_r[i] <= vld_r[i-1];
                err_r[i] <= err_r[i-1];
                dat_r[i] <= dat_r[i-1];
            end
            cnt_r <= cnt_r + CNT_W'(accept_s) - CNT_W'(io_data_ack);
        end
    end

    assign io_data_ack = vld_r[RESP_LAT-1];
    assign io_err      = err_r[RESP_LAT-1];
    assign io_rdata    = dat_r[RESP_LAT-1];

    io_mem_responder_chk #(
        .DATA_W    (DATA_W),
        .MEM_BYTES (MEM_BYTES),
        .RESP_LAT  (RESP_LAT),
        .MAX_OUTST (MAX_OUTST),
        .CNT_W     (CNT_W)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .io_req      (io_req),
        .io_req_ack  (io_req_ack),
        .io_data_ack (io_data_ack),
        .cnt         (cnt_r)
    );

endmodule

// Protocol and parameter checks for io_mem_responder (simulation only).
module io_mem_responder_chk #(
    parameter int DATA_W    = 32,
    parameter int MEM_BYTES = 256,
    parameter int RESP_LAT  = 1,
    parameter int MAX_OUTST = 1,
    parameter int CNT_W     = 1
) (
    input logic             clk,
    input logic             rst,
    input logic             io_req,
    input logic             io_req_ack,
    input logic             io_data_ack,
    input logic [CNT_W-1:0] cnt
);

    if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_data_w
        $error("io_mem_responder: DATA_W must be a multiple of 8");
    end
    if (MEM_BYTES < DATA_W / 8 || (MEM_BYTES & (MEM_BYTES - 1)) != 0) begin : g_bad_mem
        $error("io_mem_responder: MEM_BYTES must be a power of 2 >= DATA_W/8");
    end
    if (RESP_LAT < 1 || RESP_LAT > 8) begin : g_bad_lat
        $error("io_mem_responder: RESP_LAT out of range 1..8");
    end
    if (MAX_OUTST < 1 || MAX_OUTST > RESP_LAT) begin : g_bad_outst
        $error("io_mem_responder: MAX_OUTST out of range 1..RESP_LAT");
    end

    a_req_hold: assert property (@(posedge clk) disable iff (rst)
        (io_req && !io_req_ack) |=> io_req);
    a_cnt_ovf: assert property (@(posedge clk) disable iff (rst)
        cnt <= CNT_W'(MAX_OUTST));
    a_cnt_udf: assert property (@(posedge clk) disable iff (rst)
        io_data_ack |-> (cnt != '0));

endmodule

// File: tb/tb_io_mem_responder.sv
// Bench for io_mem_responder: directed table, hand sequences and randomized traffic
// checked against a transaction-level model (byte array plus timed response queue).
module tb_io_mem_responder;

    typedef struct {
        int          k;
        int          due;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    typedef struct {
        logic        wr;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [31:0] mask;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i   [2];
    logic        req_i   [2];
    logic        wr_i    [2];
    logic        stall_i [2];
    logic [3:0]  wen_i   [2];
    logic [31:0] addr_i  [2];
    logic [31:0] wdata_i [2];

    logic        a_ack, a_dack, a_err, b_ack, b_dack, b_err;
    logic [31:0] a_rdata, b_rdata;

    resp_t       pend [$];
    logic [7:0]  mm [2][256];
    int          cnt_m [2];
    int          dack_cnt [2];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    io_mem_responder #(.RESP_LAT(1), .MAX_OUTST(1)) dut_a (
        .clk(clk), .rst(rst_i[0]), .io_req(req_i[0]), .io_wr(wr_i[0]), .io_wen(wen_i[0]),
        .io_addr(addr_i[0]), .io_wdata(wdata_i[0]), .io_stall(stall_i[0]),
        .io_req_ack(a_ack), .io_rdata(a_rdata), .io_data_ack(a_dack), .io_err(a_err)
    );

    io_mem_responder #(.RESP_LAT(3), .MAX_OUTST(2)) dut_b (
        .clk(clk), .rst(rst_i[1]), .io_req(req_i[1]), .io_wr(wr_i[1]), .io_wen(wen_i[1]),
        .io_addr(addr_i[1]), .io_wdata(wdata_i[1]), .io_stall(stall_i[1]),
        .io_req_ack(b_ack), .io_rdata(b_rdata), .io_data_ack(b_dack), .io_err(b_err)
    );

    function automatic int lat(input int k);
        return (k == 1) ? 3 : 1;
    endfunction

    function automatic int maxo(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    function automatic logic ack_o(input int k);
        return (k == 1) ? b_ack : a_ack;
    endfunction

    function automatic logic dack_o(input int k);
        return (k == 1) ? b_dack : a_dack;
    endfunction

    function automatic logic err_o(input int k);
        return (k == 1) ? b_err : a_err;
    endfunction

    function automatic logic [31:0] rdata_o(input int k);
        return (k == 1) ? b_rdata : a_rdata;
    endfunction

    function automatic bit has_pend(input int k);
        foreach (pend[i]) if (pend[i].k == k) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model step for one instance: check this cycle's outputs, then apply the upcoming edge.
    task automatic mon_step(input int k, input logic ack, input logic dack,
                            input logic err, input logic [31:0] rdata);
        logic        exp_ack, exp_dack, exp_err, in_win;
        logic [31:0] exp_rd;
        int          idx;
        exp_ack = req_i[k] && !rst_i[k] && !stall_i[k] && (cnt_m[k] < maxo(k));
        idx = -1;
        foreach (pend[i]) if (idx < 0 && pend[i].k == k) idx = i;
        exp_dack = 1'b0;
        exp_err  = 1'b0;
        exp_rd   = 32'h0;
        if (idx >= 0 && pend[idx].due == cyc) begin
            exp_dack = 1'b1;
            exp_err  = pend[idx].err;
            exp_rd   = pend[idx].rdata;
        end
        chk($sformatf("req_ack[%0d]", k), {31'h0, ack}, {31'h0, exp_ack});
        chk($sformatf("data_ack[%0d]", k), {31'h0, dack}, {31'h0, exp_dack});
        chk($sformatf("err[%0d]", k), {31'h0, err}, {31'h0, exp_err});
        chk($sformatf("rdata[%0d]", k), rdata, exp_rd);
        if (dack === 1'b1) dack_cnt[k]++;
        if (rst_i[k]) begin
            for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].k == k) pend.delete(i);
            cnt_m[k] = 0;
        end else begin
            if (exp_dack) begin
                pend.delete(idx);
                cnt_m[k]--;
            end
            if (req_i[k] && exp_ack) begin
                in_win = (addr_i[k][31:8] == 24'hF0_0000);
                exp_rd = 32'h0;
                for (int i = 0; i < 4; i++) begin
                    if (in_win && !wr_i[k]) exp_rd[8*i +: 8] = mm[k][(int'(addr_i[k][7:0]) + i) % 256];
                    if (in_win && wr_i[k] && wen_i[k][i]) mm[k][(int'(addr_i[k][7:0]) + i) % 256] = wdata_i[k][8*i +: 8];
                end
                pend.push_back('{k, cyc + lat(k), !in_win, exp_rd});
                cnt_m[k]++;
            end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        mon_step(0, a_ack, a_dack, a_err, a_rdata);
        mon_step(1, b_ack, b_dack, b_err, b_rdata);
    end

    // Present a request and hold it until accepted; keep leaves io_req high for a follow-on.
    task automatic issue(input int k, input logic w, input logic [3:0] be, input logic [31:0] ad,
                         input logic [31:0] wd, input int stall_pct, input bit keep, output int acc);
        bit got;
        got = 1'b0;
        acc = -1;
        req_i[k] = 1'b1; wr_i[k] = w; wen_i[k] = be; addr_i[k] = ad; wdata_i[k] = wd;
        for (int t = 0; t < 64 && !got; t++) begin
            stall_i[k] = (int'($urandom_range(99)) < stall_pct);
            @(negedge clk);
            if (ack_o(k) === 1'b1) begin
                got = 1'b1;
                acc = cyc;
            end
            @(posedge clk); #1;
        end
        stall_i[k] = 1'b0;
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout[%0d]: got no req_ack, expected one within 64 cycles", k);
        end
        if (!keep || !got) req_i[k] = 1'b0;
    endtask

    task automatic wait_resp(input int k, input string name, input int acc, input logic [31:0] exp,
                             input logic [31:0] mask, input logic exp_err);
        bit got;
        got = 1'b0;
        for (int t = 0; t < 16 && !got; t++) begin
            @(negedge clk);
            if (dack_o(k) === 1'b1) begin
                got = 1'b1;
                chk({name, "_rdata"}, rdata_o(k) & mask, exp & mask);
                chk({name, "_err"}, {31'h0, err_o(k)}, {31'h0, exp_err});
                chk({name, "_lat"}, cyc - acc, lat(k));
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got no data_ack, expected one within 16 cycles", name);
        end
    endtask

    task automatic wait_idle(input int k);
        for (int t = 0; t < 32 && has_pend(k); t++) begin
            @(posedge clk); #1;
        end
        if (has_pend(k)) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout[%0d]: responses still pending, expected none", k);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl [14];
        int   acc, acc4 [4], d0, seen;

        tbl[0]  = '{1'b1, 4'hF, 32'hF000_0010, 32'hDEAD_BEEF, 32'h0,         32'hFFFF_FFFF, 1'b0};
        tbl[1]  = '{1'b0, 4'hF, 32'hF000_0010, 32'h0,         32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0};
        tbl[2]  = '{1'b1, 4'h1, 32'hF000_0011, 32'h0000_00AA, 32'h0,         32'hFFFF_FFFF, 1'b0};
        tbl[3]  = '{1'b0, 4'hF, 32'hF000_0010, 32'h0,         32'hDEAD_AAEF, 32'hFFFF_FFFF, 1'b0};
        tbl[4]  = '{1'b1, 4'hF, 32'hF000_00FE, 32'h1122_3344, 32'h0,         32'hFFFF_FFFF, 1'b0};
        tbl[5]  = '{1'b0, 4'hF, 32'hF000_0000, 32'h0,         32'h0000_1122, 32'h0000_FFFF, 1'b0};
        tbl[6]  = '{1'b0, 4'hF, 32'hF000_00FC, 32'h0,         32'h3344_0000, 32'hFFFF_0000, 1'b0};
        tbl[7]  = '{1'b0, 4'hF, 32'hF000_00FF, 32'h0,         32'h0011_2233, 32'h00FF_FFFF, 1'b0};
        tbl[8]  = '{1'b0, 4'hF, 32'h1000_0000, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b1};
        tbl[9]  = '{1'b1, 4'hF, 32'h1000_0010, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF, 1'b1};
        tbl[10] = '{1'b1, 4'h0, 32'hF000_0010, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF, 1'b0};
        tbl[11] = '{1'b0, 4'hF, 32'hF000_0010, 32'h0,         32'hDEAD_AAEF, 32'hFFFF_FFFF, 1'b0};
        tbl[12] = '{1'b0, 4'hF, 32'hF000_0100, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b1};
        tbl[13] = '{1'b0, 4'hF, 32'hEFFF_FFFC, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b1};

        for (int k = 0; k < 2; k++) begin
            rst_i[k] = 1'b1; req_i[k] = 1'b0; wr_i[k] = 1'b0; stall_i[k] = 1'b0;
            wen_i[k] = 4'h0; addr_i[k] = 32'h0; wdata_i[k] = 32'h0;
            cnt_m[k] = 0; dack_cnt[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_i[0] = 1'b0;
        rst_i[1] = 1'b0;

        // Fill both memories so every model byte is known.
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 64; a++) issue(k, 1'b1, 4'hF, 32'hF000_0000 + 32'(a * 4), $urandom, 0, 1'b1, acc);
            req_i[k] = 1'b0;
            wait_idle(k);
        end

        for (int i = 0; i < 14; i++) begin
            issue(0, tbl[i].wr, tbl[i].wen, tbl[i].addr, tbl[i].wdata, 0, 1'b0, acc);
            wait_resp(0, $sformatf("tbl%0d", i), acc, tbl[i].exp_rdata, tbl[i].mask, tbl[i].exp_err);
        end

        // Back-to-back reads against a 3-deep, 2-outstanding responder.
        for (int i = 0; i < 4; i++) issue(1, 1'b1, 4'hF, 32'hF000_0040 + 32'(i * 4), 32'hA5A5_0000 + 32'(i), 0, 1'b0, acc);
        wait_idle(1);
        d0 = dack_cnt[1];
        for (int i = 0; i < 4; i++) issue(1, 1'b0, 4'hF, 32'hF000_0040 + 32'(i * 4), 32'h0, 0, (i < 3), acc4[i]);
        wait_idle(1);
        chk("b2b_acc1", acc4[1] - acc4[0], 32'd1);
        chk("b2b_acc2", acc4[2] - acc4[0], 32'd4);
        chk("b2b_acc3", acc4[3] - acc4[0], 32'd5);
        chk("b2b_acks", dack_cnt[1] - d0, 32'd4);

        // Stall with one in flight: the response still lands, nothing new is accepted.
        issue(1, 1'b0, 4'hF, 32'hF000_0040, 32'h0, 0, 1'b1, acc);
        addr_i[1] = 32'hF000_0044;
        stall_i[1] = 1'b1;
        d0 = dack_cnt[1];
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (b_ack === 1'b1) seen = 1;
            @(posedge clk); #1;
        end
        chk("stall_no_accept", seen, 32'd0);
        chk("stall_resp_delivered", dack_cnt[1] - d0, 32'd1);
        stall_i[1] = 1'b0;

        // Reset with two in flight: both responses dropped, memory retained.
        issue(1, 1'b0, 4'hF, 32'hF000_0044, 32'h0, 0, 1'b1, acc);
        issue(1, 1'b0, 4'hF, 32'hF000_0048, 32'h0, 0, 1'b0, acc);
        rst_i[1] = 1'b1;
        d0 = dack_cnt[1];
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_i[1] = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        chk("rst_drops_resp", dack_cnt[1] - d0, 32'd0);
        issue(1, 1'b0, 4'hF, 32'hF000_0044, 32'h0, 0, 1'b0, acc);
        wait_resp(1, "rst_retained", acc, 32'hA5A5_0001, 32'hFFFF_FFFF, 1'b0);

        // Randomized traffic with stalls and idle gaps, checked by the model.
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 250; n++) begin
                logic [31:0] ad;
                ad = ($urandom_range(9) < 8) ? {24'hF0_0000, 8'($urandom)} : $urandom;
                issue(k, 1'($urandom_range(1)), 4'($urandom), ad, $urandom, 25, 1'b1, acc);
                if ($urandom_range(3) == 0) begin
                    req_i[k] = 1'b0;
                    repeat ($urandom_range(1, 4)) begin
                        @(posedge clk); #1;
                    end
                end
            end
            req_i[k] = 1'b0;
            wait_idle(k);
        end

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
